// File: rtl/seven_segment_scanner.sv
// Multiplexed common-anode seven-segment driver with a double-buffered frame load,
// per-digit dp/blank/blink, leading-zero suppression and PWM brightness.
module seven_segment_scanner #(
    parameter int NUM_DIGITS   = 8,
    parameter int COUNT_PERIOD = 100000,
    parameter int BLINK_FRAMES = 64,
    parameter int BRIGHT_BITS  = 4
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [4*NUM_DIGITS-1:0] val_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic [NUM_DIGITS-1:0]   blink_in,
    input  logic                    lz_en_in,
    input  logic [BRIGHT_BITS-1:0]  bright_in,
    input  logic                    load_in,
    output logic                    pending_out,
    output logic                    frame_start_out,
    output logic [6:0]              cat_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an_out
);

    localparam int SLOT_W = $clog2(COUNT_PERIOD + 1);
    localparam int DIG_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FRM_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [SLOT_W-1:0] SLOT_MAX = SLOT_W'(COUNT_PERIOD);
    localparam logic [DIG_W-1:0]  DIG_MAX  = DIG_W'(NUM_DIGITS - 1);
    localparam logic [FRM_W-1:0]  FRM_MAX  = FRM_W'(BLINK_FRAMES - 1);

    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] val;
        logic [NUM_DIGITS-1:0]   dp;
        logic [NUM_DIGITS-1:0]   blank;
        logic [NUM_DIGITS-1:0]   blink;
        logic                    lz_en;
        logic [BRIGHT_BITS-1:0]  bright;
    } cfg_t;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    logic [SLOT_W-1:0]      slot_q, slot_d;
    logic [DIG_W-1:0]       digit_q, digit_d;
    logic [FRM_W-1:0]       frame_q, frame_d;
    logic                   phase_q, phase_d;
    logic [BRIGHT_BITS-1:0] pwm_q, pwm_d;
    cfg_t                   pend_q, pend_d;
    cfg_t                   act_q, act_d;
    logic                   pending_q, pending_d;
    logic                   seen_q, seen_d;
    logic [NUM_DIGITS-1:0]  an_q, an_d;
    logic [6:0]             cat_q, cat_d;
    logic                   dp_q, dp_d;
    logic                   fs_q, fs_d;

    logic                   boundary;
    logic                   zero_run;
    logic [NUM_DIGITS-1:0]  supp;
    logic [NUM_DIGITS-1:0]  an_sel;
    logic [3:0]             cur_nib;
    logic                   cur_dp, cur_blank, cur_blink, cur_supp;
    logic                   gate, lit;

    // Digit k is suppressed when it and every digit above it hold zero.
    always_comb begin
        zero_run = 1'b1;
        supp     = '0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run = zero_run & (act_q.val[4*k +: 4] == 4'h0);
            supp[k]  = act_q.lz_en & zero_run;
        end
    end

    always_comb begin
        boundary  = (slot_q == SLOT_MAX) && (digit_q == DIG_MAX);

        slot_d    = slot_q + 1'b1;
        digit_d   = digit_q;
        frame_d   = frame_q;
        phase_d   = phase_q;
        pwm_d     = pwm_q + 1'b1;
        pend_d    = pend_q;
        act_d     = act_q;
        pending_d = pending_q;
        seen_d    = seen_q | boundary;

        if (slot_q == SLOT_MAX) begin
            slot_d  = '0;
            digit_d = (digit_q == DIG_MAX) ? '0 : digit_q + 1'b1;
        end

        if (boundary) begin
            if (frame_q == FRM_MAX) begin
                frame_d = '0;
                phase_d = ~phase_q;
            end else begin
                frame_d = frame_q + 1'b1;
            end
        end

        // A load in the boundary cycle still hands the older pending set over first.
        if (boundary && pending_q) begin
            act_d     = pend_q;
            pending_d = 1'b0;
        end
        if (load_in) begin
            pend_d.val    = val_in;
            pend_d.dp     = dp_in;
            pend_d.blank  = blank_in;
            pend_d.blink  = blink_in;
            pend_d.lz_en  = lz_en_in;
            pend_d.bright = bright_in;
            pending_d     = 1'b1;
        end

        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b1;
        cur_blink = 1'b0;
        cur_supp  = 1'b0;
        an_sel    = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (digit_q == DIG_W'(k)) begin
                cur_nib   = act_q.val[4*k +: 4];
                cur_dp    = act_q.dp[k];
                cur_blank = act_q.blank[k];
                cur_blink = act_q.blink[k];
                cur_supp  = supp[k];
                an_sel[k] = 1'b0;
            end
        end

        gate = (pwm_q <= act_q.bright);
        lit  = !cur_blank && !(cur_blink && phase_q) && gate;

        an_d  = lit ? an_sel : '1;
        cat_d = (lit && !cur_supp) ? ~seg_decode(cur_nib) : 7'h7F;
        dp_d  = !(lit && cur_dp);
        fs_d  = seen_q && (slot_q == '0) && (digit_q == '0);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            slot_q       <= '0;
            digit_q      <= '0;
            frame_q      <= '0;
            phase_q      <= 1'b0;
            pwm_q        <= '0;
            pend_q       <= '0;
            act_q        <= '0;
            act_q.blank  <= '1;
            act_q.bright <= '1;
            pending_q    <= 1'b0;
            seen_q       <= 1'b0;
            an_q         <= '1;
            cat_q        <= 7'h7F;
            dp_q         <= 1'b1;
            fs_q         <= 1'b0;
        end else begin
            slot_q    <= slot_d;
            digit_q   <= digit_d;
            frame_q   <= frame_d;
            phase_q   <= phase_d;
            pwm_q     <= pwm_d;
            pend_q    <= pend_d;
            act_q     <= act_d;
            pending_q <= pending_d;
            seen_q    <= seen_d;
            an_q      <= an_d;
            cat_q     <= cat_d;
            dp_q      <= dp_d;
            fs_q      <= fs_d;
        end
    end

    assign pending_out     = pending_q;
    assign frame_start_out = fs_q;
    assign cat_out         = cat_q;
    assign dp_out          = dp_q;
    assign an_out          = an_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Directed bench for seven_segment_scanner with 4 digits, 4-clock slots,
// 2-frame blink half-period and 2-bit brightness.
module tb_seven_segment_scanner;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [15:0] val_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_in = '0;
    logic [3:0]  blink_in = '0;
    logic        lz_en_in = 1'b0;
    logic [1:0]  bright_in = '0;
    logic        load_in = 1'b0;
    logic        pending_out;
    logic        frame_start_out;
    logic [6:0]  cat_out;
    logic        dp_out;
    logic [3:0]  an_out;

    seven_segment_scanner #(
        .NUM_DIGITS  (4),
        .COUNT_PERIOD(3),
        .BLINK_FRAMES(2),
        .BRIGHT_BITS (2)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .val_in         (val_in),
        .dp_in          (dp_in),
        .blank_in       (blank_in),
        .blink_in       (blink_in),
        .lz_en_in       (lz_en_in),
        .bright_in      (bright_in),
        .load_in        (load_in),
        .pending_out    (pending_out),
        .frame_start_out(frame_start_out),
        .cat_out        (cat_out),
        .dp_out         (dp_out),
        .an_out         (an_out)
    );

    always #5 clk_in = ~clk_in;

    int vectors = 0;
    int miscompares = 0;

    // Bench-side frame position: scan = position the DUT is in before the next edge,
    // out_pos = position the registered outputs currently reflect.
    int scan = 0;
    int out_pos = 0;
    int nb = 0;
    int out_nb = 0;
    bit out_valid = 1'b0;

    task automatic tick();
        @(posedge clk_in);
        if (rst_in) begin
            scan = 0;
            nb = 0;
            out_valid = 1'b0;
        end else begin
            out_pos = scan;
            out_nb = nb;
            out_valid = 1'b1;
            if (scan == 15) nb++;
            scan = (scan + 1) % 16;
        end
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h (pos %0d)", tag, obs, exp, out_pos);
        end
    endtask

    task automatic wait_pos(input int p);
        int n = 0;
        while (!(out_valid && out_pos == p) && n < 64) begin
            tick();
            n++;
        end
        if (n >= 64) begin
            vectors++;
            miscompares++;
            $error("FAIL wait_pos: observed timeout expected pos %0d", p);
        end
    endtask

    task automatic wait_scan(input int s);
        int n = 0;
        while (scan != s && n < 64) begin
            tick();
            n++;
        end
        if (n >= 64) begin
            vectors++;
            miscompares++;
            $error("FAIL wait_scan: observed timeout expected scan %0d", s);
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl,
                           input logic [3:0] bk, input logic lz, input logic [1:0] br);
        val_in = v;
        dp_in = dp;
        blank_in = bl;
        blink_in = bk;
        lz_en_in = lz;
        bright_in = br;
        load_in = 1'b1;
        tick();
        load_in = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] an_tab [4];
        logic [15:0] c1234 [4];
        logic [15:0] ea, ec;
        bit          lit_f [4];
        bit          lit;
        int          ph, d;

        an_tab[0] = 16'hE; an_tab[1] = 16'hD; an_tab[2] = 16'hB; an_tab[3] = 16'h7;
        c1234[0] = 16'h19; c1234[1] = 16'h30; c1234[2] = 16'h24; c1234[3] = 16'h79;

        // reset
        repeat (3) tick();
        chk("rst_an", 16'(an_out), 16'hF);
        chk("rst_cat", 16'(cat_out), 16'h7F);
        chk("rst_dp", 16'(dp_out), 16'h1);
        chk("rst_pend", 16'(pending_out), 16'h0);
        chk("rst_fs", 16'(frame_start_out), 16'h0);
        rst_in = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("dark_an", 16'(an_out), 16'hF);
            chk("first_fs", 16'(frame_start_out), (i == 16) ? 16'h1 : 16'h0);
        end

        // scan order
        do_load(16'h1234, 4'h0, 4'h0, 4'h0, 1'b0, 2'd3);
        chk("pend_set", 16'(pending_out), 16'h1);
        wait_pos(0);
        chk("pend_clr", 16'(pending_out), 16'h0);
        for (int i = 0; i < 16; i++) begin
            chk("scan_an", 16'(an_out), an_tab[i/4]);
            chk("scan_cat", 16'(cat_out), c1234[i/4]);
            chk("scan_dp", 16'(dp_out), 16'h1);
            chk("scan_fs", 16'(frame_start_out), (i == 0) ? 16'h1 : 16'h0);
            tick();
        end

        // double buffering
        do_load(16'h1111, 4'h0, 4'h0, 4'h0, 1'b0, 2'd3);
        repeat (3) tick();
        do_load(16'h2222, 4'h0, 4'h0, 4'h0, 1'b0, 2'd3);
        chk("dbl_pend", 16'(pending_out), 16'h1);
        wait_pos(15);
        chk("dbl_old", 16'(cat_out), 16'h79);
        tick();
        for (int i = 0; i < 16; i++) begin
            chk("dbl_cat", 16'(cat_out), 16'h24);
            chk("dbl_an", 16'(an_out), an_tab[i/4]);
            tick();
        end
        do_load(16'h4444, 4'h0, 4'h0, 4'h0, 1'b0, 2'd3);
        wait_scan(15);
        do_load(16'h5555, 4'h0, 4'h0, 4'h0, 1'b0, 2'd3);
        chk("coin_pend", 16'(pending_out), 16'h1);
        chk("coin_last", 16'(cat_out), 16'h24);
        tick();
        chk("coin_new", 16'(cat_out), 16'h19);
        wait_pos(8);
        chk("coin_pend_mid", 16'(pending_out), 16'h1);
        chk("coin_cat_mid", 16'(cat_out), 16'h19);
        chk("coin_an_mid", 16'(an_out), 16'hB);
        wait_pos(0);
        chk("coin_pend_clr", 16'(pending_out), 16'h0);
        chk("coin_cat_next", 16'(cat_out), 16'h12);
        chk("coin_an_next", 16'(an_out), 16'hE);

        // leading zeros
        do_load(16'h0050, 4'b1000, 4'h0, 4'h0, 1'b1, 2'd3);
        wait_pos(0);
        chk("lz_d0_cat", 16'(cat_out), 16'h40);
        chk("lz_d0_an", 16'(an_out), 16'hE);
        chk("lz_d0_dp", 16'(dp_out), 16'h1);
        wait_pos(4);
        chk("lz_d1_cat", 16'(cat_out), 16'h12);
        chk("lz_d1_an", 16'(an_out), 16'hD);
        wait_pos(8);
        chk("lz_d2_cat", 16'(cat_out), 16'h7F);
        chk("lz_d2_dp", 16'(dp_out), 16'h1);
        wait_pos(12);
        chk("lz_d3_cat", 16'(cat_out), 16'h7F);
        chk("lz_d3_dp", 16'(dp_out), 16'h0);
        chk("lz_d3_an", 16'(an_out), 16'h7);
        do_load(16'h0000, 4'h0, 4'h0, 4'h0, 1'b1, 2'd3);
        wait_pos(0);
        chk("lz0_d0_cat", 16'(cat_out), 16'h40);
        chk("lz0_d0_an", 16'(an_out), 16'hE);
        wait_pos(4);
        chk("lz0_d1_cat", 16'(cat_out), 16'h7F);
        wait_pos(8);
        chk("lz0_d2_cat", 16'(cat_out), 16'h7F);
        wait_pos(12);
        chk("lz0_d3_cat", 16'(cat_out), 16'h7F);

        // blink + PWM: digit 0 shows 8 and blinks, digit 1 shows 0 steadily
        do_load(16'h0008, 4'h0, 4'h0, 4'b0001, 1'b0, 2'd1);
        for (int f = 0; f < 4; f++) begin
            wait_pos(0);
            for (int p = 0; p < 8; p++) begin
                ph = (out_nb / 2) % 2;
                d = p / 4;
                lit = ((p % 4) < 2) && !(d == 0 && ph == 1);
                ea = lit ? ((d == 0) ? 16'hE : 16'hD) : 16'hF;
                ec = lit ? ((d == 0) ? 16'h00 : 16'h40) : 16'h7F;
                if (p == 0) lit_f[f] = (an_out[0] == 1'b0);
                chk("blink_an", 16'(an_out), ea);
                chk("blink_cat", 16'(cat_out), ec);
                tick();
            end
        end
        chk("blink_pair", 16'(lit_f[0] ^ lit_f[2]), 16'h1);
        chk("blink_hold", 16'(lit_f[2] ^ lit_f[3]), 16'h0);

        // reset mid-frame with a pending load
        wait_pos(0);
        do_load(16'h9999, 4'hF, 4'h0, 4'h0, 1'b0, 2'd3);
        wait_pos(8);
        chk("mid_pend", 16'(pending_out), 16'h1);
        rst_in = 1'b1;
        tick();
        chk("mrst_an", 16'(an_out), 16'hF);
        chk("mrst_cat", 16'(cat_out), 16'h7F);
        chk("mrst_dp", 16'(dp_out), 16'h1);
        chk("mrst_pend", 16'(pending_out), 16'h0);
        chk("mrst_fs", 16'(frame_start_out), 16'h0);
        rst_in = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("mrst_dark", 16'(an_out), 16'hF);
        end
        chk("mrst_pend_end", 16'(pending_out), 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seven_segment_scanner.md
# seven_segment_scanner

Parametrised multiplexed seven-segment driver. It supersedes the fixed 8-digit controller by adding:
- a configurable digit count;
- per-digit decimal point, blanking and blinking;
- leading-zero suppression;
- PWM brightness;
- a double-buffered load handshake, so a displayed frame never mixes old and new data.

It sits between the game/debug logic and the board's common-anode display pins.

## Interface
- NUM_DIGITS, 8, number of multiplexed digits (1..16)
- COUNT_PERIOD, 100000, digit slot length is COUNT_PERIOD+1 clocks (COUNT_PERIOD ≥ 1)
- BLINK_FRAMES, 64, number of frames per blink half-period (≥ 1)
- BRIGHT_BITS, 4, brightness resolution in bits

- clk_in  in  1  system clock; single clock domain
- rst_in  in  1  synchronous, active-high reset
- val_in  in  4*NUM_DIGITS  hex nibbles; digit k = val_in[4k+:4]
- dp_in  in  NUM_DIGITS  decimal point enable per digit
- blank_in  in  NUM_DIGITS  force digit dark
- blink_in  in  NUM_DIGITS  digit blinks
- lz_en_in  in  1  leading-zero suppression enable
- bright_in  in  BRIGHT_BITS  brightness code
- load_in  in  1  single-cycle strobe; captures all of the above
- pending_out  out  1  loaded data waiting for the next frame boundary
- frame_start_out  out  1  one-cycle pulse when digit 0 of a new frame is first driven
- cat_out  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp_out  out  1  decimal point, active-low
- an_out  out  NUM_DIGITS  digit anodes, active-low; bit k = digit k

## Operation

**Registers**
- Three register sets: pending, active, and scan state.
- On `load_in`, capture `val_in`, `dp_in`, `blank_in`, `blink_in`, `lz_en_in` and `bright_in` into pending, and set `pending_out`.
- A second load before the boundary overwrites pending.

**Frame boundary**
- The boundary is the cycle where slot counter == COUNT_PERIOD and digit index == NUM_DIGITS-1.
- At the boundary, if `pending_out` is set: copy pending into active and clear `pending_out`.
- Load and boundary in the same cycle: the old pending contents transfer to active. The new data goes into pending and `pending_out` stays 1.

**Scan**
- The slot counter counts 0..COUNT_PERIOD, then wraps to 0.
- On wrap, digit index increments modulo NUM_DIGITS. Wrap handling is explicit, so non-power-of-2 NUM_DIGITS is correct.

**Blink**
- The frame counter counts boundaries 0..BLINK_FRAMES-1.
- On wrap, `blink_phase` toggles.
- A digit with active blink set is dark while `blink_phase` = 1.

**Leading-zero suppression (lz_en)**
- Digit k (k ≥ 1) is suppressed if its nibble and all higher nibbles are 0.
- Digit 0 is never suppressed.
- A suppressed digit's segments are dark, but its decimal point is still shown.

**Digit lit / segment decode**
- A digit is lit when it is not blank, not in its blink-off phase, and the PWM gate is open.
- Suppression only darkens segments; it does not affect the decimal point.
- Standard hex decode. Active-high patterns:
  - 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66, 5 = 6D, 6 = 7D, 7 = 07
  - 8 = 7F, 9 = 6F, A = 77, b = 7C, C = 39, d = 5E, E = 79, F = 71
- `cat_out` is the bitwise inverse of the pattern.

**PWM**
- A free-running BRIGHT_BITS-bit counter `pwm` increments every clock.
- The gate is open while `pwm` ≤ active bright.
- Duty = (bright+1)/2^BRIGHT_BITS; the maximum code gives full on.
- When the gate is closed, `an_out` is all ones.

## Timing
- `cat_out`, `dp_out`, `an_out` and `frame_start_out` are registered: one cycle after the scan state they reflect.
- Reset values:
  - outputs: `an_out` all 1s, `cat_out` 7'h7F, `dp_out` 1, `frame_start_out` 0, `pending_out` 0;
  - scan state: slot counter 0, digit 0, frame counter 0, `blink_phase` 0, `pwm` 0;
  - active set: val 0, dp 0, blank all 1s (display dark until the first load crosses a boundary), blink 0, lz_en 0, bright all 1s;
  - pending set: cleared.
- Digit k is driven for exactly COUNT_PERIOD+1 consecutive cycles (modulo PWM gating).
- A full frame is NUM_DIGITS*(COUNT_PERIOD+1) cycles.
- Load-to-display latency: from the load cycle until the first output cycle after the next boundary. Worst case is one frame + 1 cycle.
- Never more than one `an_out` bit is low in any cycle.
- `frame_start_out` is not asserted for the first frame after reset.
- Reset mid-frame: all outputs take their reset values the next cycle, and pending data is discarded.

## Test plan
Use bench parameters NUM_DIGITS=4, COUNT_PERIOD=3, BLINK_FRAMES=2, BRIGHT_BITS=2.

1. **Reset:** hold `rst_in` 3 cycles → `an_out`=4'hF, `cat_out`=7'h7F, `dp_out`=1, `pending_out`=0, and the display stays dark until a load.
2. **Scan order:** load val=16'h1234, blank=0, bright=3 → after the next boundary, slots show (digit 0, 7'h19 = "4"), (1, 7'h30 = "3"), (2, 7'h24 = "2"), (3, 7'h79 = "1"). Each slot lasts 4 cycles, `an_out` is 1110/1101/1011/0111, and the period is 16 cycles.
3. **Double buffering:** load 16'h1111, then load 16'h2222 mid-frame → only "2" is displayed after the boundary, never a mixed frame. A load coinciding with the boundary leaves `pending_out`=1 for one more frame.
4. **Leading zeros:** load val=16'h0050, lz_en=1, dp=4'b1000 → digits 3 and 2 have segments dark, digit 3 `dp_out`=0, and digits 1/0 show "5"/"0". Repeat with val=16'h0000 → only digit 0 shows "0".
5. **Blink + PWM:** blink=4'b0001, bright=1 → digit 0 is dark for 2 frames then lit for 2 frames, cycling. While lit, `an_out` bit is low for 2 of every 4 cycles (`pwm` 0,1).
6. **Reset mid-frame:** assert `rst_in` during digit 2 with a pending load → next cycle all outputs are at reset values, `pending_out`=0, and the old data is not displayed.
